// File: rtl/sync_timing_pkg.sv
// rtl/sync_timing_pkg.sv - shared widths and compare values for the video sync counters
// Imported by the sync controller and by sync_count_gen, so both sides use
// the same terminal counts and counter widths.
package sync_timing_pkg;

    localparam int CNT_W_DEF  = 10;
    localparam int PCNT_W_DEF = 8;

    // Line-position compare values (cnt).
    localparam int CNT_V10  = 10;
    localparam int CNT_V13  = 13;
    localparam int CNT_V21  = 21;
    localparam int CNT_V44  = 44;
    localparam int CNT_V45  = 45;
    localparam int CNT_V261 = 261;
    localparam int CNT_V272 = 272;
    localparam int CNT_V283 = 283;
    localparam int CNT_V284 = 284;
    localparam int CNT_V509 = 509;
    localparam int CNT_V511 = 511;
    localparam int CNT_V567 = 567;
    localparam int CNT_V591 = 591;

    // Pulse / line-group compare values (pcnt).
    localparam int PCNT_V6   = 6;
    localparam int PCNT_V12  = 12;
    localparam int PCNT_V17  = 17;
    localparam int PCNT_V27  = 27;
    localparam int PCNT_V241 = 241;

endpackage

// File: rtl/sync_count_gen_if.sv
// rtl/sync_count_gen_if.sv - strobe/flag bundle between the sync controller and sync_count_gen
// Signals:
//   cen, cclr, pclr, pc          strobes from the controller
//   cnt*, pcnt*                  terminal-count flags back to the controller
//   cnt_ovf, pcnt_ovf            sticky wrap flags
//   cnt_q, pcnt_q                current counter values (debug)
// Modports: master = controller side, slave = counter block side.
interface sync_count_gen_if
    import sync_timing_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PCNT_W = PCNT_W_DEF
);
    logic cen;
    logic cclr;
    logic pclr;
    logic pc;

    logic cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272;
    logic cnt283, cnt284, cnt509, cnt511, cnt567, cnt591;
    logic pcnt6, pcnt12, pcnt17, pcnt27, pcnt241;

    logic              cnt_ovf;
    logic              pcnt_ovf;
    logic [CNT_W-1:0]  cnt_q;
    logic [PCNT_W-1:0] pcnt_q;

    modport master (
        output cen, cclr, pclr, pc,
        input  cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272,
        input  cnt283, cnt284, cnt509, cnt511, cnt567, cnt591,
        input  pcnt6, pcnt12, pcnt17, pcnt27, pcnt241,
        input  cnt_ovf, pcnt_ovf, cnt_q, pcnt_q
    );

    modport slave (
        input  cen, cclr, pclr, pc,
        output cnt10, cnt13, cnt21, cnt44, cnt45, cnt261, cnt272,
        output cnt283, cnt284, cnt509, cnt511, cnt567, cnt591,
        output pcnt6, pcnt12, pcnt17, pcnt27, pcnt241,
        output cnt_ovf, pcnt_ovf, cnt_q, pcnt_q
    );

endinterface

// File: rtl/sync_count_reg.sv
// rtl/sync_count_reg.sv - width-parameterised counter with clear priority and sticky overflow
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears q and ovf)
//   clr    synchronous clear, wins over inc; does not touch ovf
//   inc    increment, wraps modulo 2^W
//   q      counter value
//   ovf    set when an increment wraps from all-ones to zero, held until reset
module sync_count_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         ovf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= q + W'(1);
            if (&q) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_count_gen.sv
// rtl/sync_count_gen.sv - line-position and pulse counters with terminal-count decode
// Ports:
//   CK   rising-edge clock
//   RN   asynchronous active-low reset
//   sif  slave side of sync_count_gen_if: strobes in, flags/ovf/counts out
// Flags are combinational decodes of the registered counts, so a strobe
// sampled on one edge shows up on the flags right after that edge.
module sync_count_gen
    import sync_timing_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PCNT_W = PCNT_W_DEF
) (
    input  logic             CK,
    input  logic             RN,
    sync_count_gen_if.slave  sif
);

    // Largest compare values are 591 and 241; narrower counters could never match.
    generate
        if (CNT_W < 10) begin : g_cnt_w_chk
            $error("sync_count_gen: CNT_W must be at least 10");
        end
        if (PCNT_W < 8) begin : g_pcnt_w_chk
            $error("sync_count_gen: PCNT_W must be at least 8");
        end
    endgenerate

    logic [CNT_W-1:0]  cnt;
    logic [PCNT_W-1:0] pcnt;

    sync_count_reg #(.W(CNT_W)) u_cnt (
        .clk   (CK),
        .rst_n (RN),
        .clr   (sif.cclr),
        .inc   (sif.cen),
        .q     (cnt),
        .ovf   (sif.cnt_ovf)
    );

    sync_count_reg #(.W(PCNT_W)) u_pcnt (
        .clk   (CK),
        .rst_n (RN),
        .clr   (sif.pclr),
        .inc   (sif.pc),
        .q     (pcnt),
        .ovf   (sif.pcnt_ovf)
    );

    assign sif.cnt_q  = cnt;
    assign sif.pcnt_q = pcnt;

    // No compare value is zero, so every flag is low while in reset.
    assign sif.cnt10  = (cnt == CNT_W'(CNT_V10));
    assign sif.cnt13  = (cnt == CNT_W'(CNT_V13));
    assign sif.cnt21  = (cnt == CNT_W'(CNT_V21));
    assign sif.cnt44  = (cnt == CNT_W'(CNT_V44));
    assign sif.cnt45  = (cnt == CNT_W'(CNT_V45));
    assign sif.cnt261 = (cnt == CNT_W'(CNT_V261));
    assign sif.cnt272 = (cnt == CNT_W'(CNT_V272));
    assign sif.cnt283 = (cnt == CNT_W'(CNT_V283));
    assign sif.cnt284 = (cnt == CNT_W'(CNT_V284));
    assign sif.cnt509 = (cnt == CNT_W'(CNT_V509));
    assign sif.cnt511 = (cnt == CNT_W'(CNT_V511));
    assign sif.cnt567 = (cnt == CNT_W'(CNT_V567));
    assign sif.cnt591 = (cnt == CNT_W'(CNT_V591));

    assign sif.pcnt6   = (pcnt == PCNT_W'(PCNT_V6));
    assign sif.pcnt12  = (pcnt == PCNT_W'(PCNT_V12));
    assign sif.pcnt17  = (pcnt == PCNT_W'(PCNT_V17));
    assign sif.pcnt27  = (pcnt == PCNT_W'(PCNT_V27));
    assign sif.pcnt241 = (pcnt == PCNT_W'(PCNT_V241));

endmodule
